dpram_be_clr: RTL

Parametrised simple-dual-port RAM: one write port with byte enables, `nRPORTS` independent read ports with read enables, selectable 1- or 2-cycle read latency, and per-port write-to-read forwarding. A hardware clear engine zeroes the array after every reset. It is the generalised successor to the single-read-port bypass RAM, for Sephirot register and map storage where several lanes read one table concurrently.

---
 rtl/dpram_be_clr.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dpram_be_clr.sv
// dpram_be_clr: simple-dual-port RAM with one byte-enabled write port,
// nRPORTS independent read ports, 1- or 2-cycle read latency, optional
// same-cycle write-to-read forwarding, and a clear engine that zeroes the
// array after every reset.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | zeroing one word per edge at clr_cnt; port requests ignored
// READY | normal operation; terminal until the next rst
module dpram_be_clr #(
  parameter int MEMD    = 16,
  parameter int DATAW   = 32,
  parameter int nRPORTS = 2,
  parameter int RLAT    = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = (MEMD > 1) ? $clog2(MEMD) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       Busy,
  input  logic                       WEnb,
  input  logic [DATAW/8-1:0]         WBe,
  input  logic [AW-1:0]              WAddr,
  input  logic [DATAW-1:0]           WData,
  input  logic [nRPORTS-1:0]         REnb,
  input  logic [nRPORTS*AW-1:0]      RAddr,
  output logic [nRPORTS*DATAW-1:0]   RData,
  output logic [nRPORTS-1:0]         RValid
);

  localparam int NBE = DATAW / 8;
  // One extra bit so MEMD itself is representable for the range compare.
  localparam logic [AW:0]   MEMD_W = (AW+1)'(MEMD);
  localparam logic [AW-1:0] LAST   = AW'(MEMD - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [AW-1:0]       clr_cnt;
  logic [DATAW-1:0]    mem [MEMD];
  logic [DATAW-1:0]    wmask;
  logic                wr_ok;

  assign wr_ok = !Busy && WEnb && ({1'b0, WAddr} < MEMD_W);

  // Byte enables expanded to a bit mask, shared by the array write and forwarding.
  always_comb begin
    wmask = '0;
    for (int k = 0; k < NBE; k++) begin
      wmask[8*k +: 8] = {8{WBe[k]}};
    end
  end

  // Clear sequencer: walk the counter from 0 to MEMD-1, then release Busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      Busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state <= READY;
            Busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        default: begin
          state <= READY;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write: zero fill while clearing, byte-lane merge once ready.
  always_ff @(posedge clk) begin
    if (Busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NBE; k++) begin
        if (WBe[k]) mem[WAddr][8*k +: 8] <= WData[8*k +: 8];
      end
    end
  end

  for (genvar i = 0; i < nRPORTS; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             rd_ok;
    logic             in_rng;
    logic             hit;
    logic             v1;
    logic [DATAW-1:0] raw1;
    logic [DATAW-1:0] wd1;
    logic [DATAW-1:0] wm1;
    logic [DATAW-1:0] merged;

    assign ra     = RAddr[i*AW +: AW];
    assign in_rng = ({1'b0, ra} < MEMD_W);
    assign rd_ok  = !Busy && REnb[i];
    assign hit    = (BYPASS != 0) && wr_ok && in_rng && (WAddr == ra);

    // Stage 1: capture the pre-write word plus the same-edge write for merging.
    // Loaded only on an accepted read, so the result holds between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1   <= 1'b0;
        raw1 <= '0;
        wd1  <= '0;
        wm1  <= '0;
      end else begin
        v1 <= rd_ok;
        if (rd_ok) begin
          raw1 <= in_rng ? mem[ra] : '0;
          wd1  <= WData;
          wm1  <= hit ? wmask : '0;
        end
      end
    end

    assign merged = (raw1 & ~wm1) | (wd1 & wm1);

    if (RLAT == 2) begin : g_lat2
      logic             v2;
      logic [DATAW-1:0] d2;

      // Stage 2: extra output register; the merge already used the edge-t write only.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= merged;
        end
      end

      assign RData[i*DATAW +: DATAW] = d2;
      assign RValid[i]               = v2;
    end else begin : g_lat1
      assign RData[i*DATAW +: DATAW] = merged;
      assign RValid[i]               = v1;
    end
  end

endmodule
